// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared signed-digit types, width constant and value helper
package sd_pkg;

  localparam int SD_DIGITS = 4;

  // One SD digit: value = plus - minus; {1,1} is a legal zero
  typedef struct packed {
    logic plus;
    logic minus;
  } sd_digit_t;

  // Carry pair: [1]=plus rail, [0]=minus rail
  typedef logic [1:0] sd_carry_t;

  function automatic int sd_value(input logic [SD_DIGITS-1:0] plus_v,
                                  input logic [SD_DIGITS-1:0] minus_v);
    return int'(plus_v) - int'(minus_v);
  endfunction

endpackage

// File: rtl/sd_adder_m_slice_if.sv
// rtl/sd_adder_m_slice_if.sv - datapath bundle of the SD adder / M slice
interface sd_adder_m_slice_if;
  import sd_pkg::*;

  logic                 carry_en;
  logic [SD_DIGITS-1:0] x_plus;
  logic [SD_DIGITS-1:0] x_minus;
  logic [SD_DIGITS-1:0] y_plus;
  logic [SD_DIGITS-1:0] y_minus;
  logic [SD_DIGITS-1:0] residue_plus;
  logic [SD_DIGITS-1:0] residue_minus;
  logic [SD_DIGITS-1:0] sum_plus;
  logic [SD_DIGITS-1:0] sum_minus;
  sd_carry_t            cout_one;
  sd_carry_t            cout_two;
  sd_carry_t            cin_one;
  sd_carry_t            cin_two;
  logic [SD_DIGITS-1:0] v_top_plus;
  logic [SD_DIGITS-1:0] v_top_minus;
  logic [1:0]           p;
  logic [2:0]           w_upper_plus;
  logic [2:0]           w_upper_minus;

  modport master (
    output carry_en, x_plus, x_minus, y_plus, y_minus,
           residue_plus, residue_minus, v_top_plus, v_top_minus, p,
    input  sum_plus, sum_minus, cout_one, cout_two, cin_one, cin_two,
           w_upper_plus, w_upper_minus
  );

  modport slave (
    input  carry_en, x_plus, x_minus, y_plus, y_minus,
           residue_plus, residue_minus, v_top_plus, v_top_minus, p,
    output sum_plus, sum_minus, cout_one, cout_two, cin_one, cin_two,
           w_upper_plus, w_upper_minus
  );

endinterface

// File: rtl/sd_carry_reg.sv
// rtl/sd_carry_reg.sv - 2-bit enable-gated carry flop with asynchronous reset
module sd_carry_reg
  import sd_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      en_i,
  input  sd_carry_t d_i,
  output sd_carry_t q_o
);

  sd_carry_t q_q;
  sd_carry_t q_d;

  always_comb begin
    q_d = q_q;
    if (en_i) begin
      q_d = d_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/sd_adder_m_slice.sv
// rtl/sd_adder_m_slice.sv - 4-digit SD three-operand adder slice plus M selection-subtract
// Optional feature macro: SD_M_OVF_FLAG_EN adds the m_ovf saturation flag output.
module sd_adder_m_slice
  import sd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  sd_adder_m_slice_if.slave bus
`ifdef SD_M_OVF_FLAG_EN
  ,
  output logic              m_ovf
`endif
);

  logic [DIGITS:0]   st1_plus;
  logic [DIGITS:0]   st1_minus;
  logic [DIGITS:0]   st2_plus;
  logic [DIGITS:0]   st2_minus;
  sd_carry_t         cout_one_d;
  sd_carry_t         cout_two_d;

  // Each rail is an independent unsigned chain; stage 2 consumes stage 1's low digits
  always_comb begin
    st1_plus  = {1'b0, bus.x_plus}  + {1'b0, bus.y_plus}  + {{DIGITS{1'b0}}, bus.cin_one[1]};
    st1_minus = {1'b0, bus.x_minus} + {1'b0, bus.y_minus} + {{DIGITS{1'b0}}, bus.cin_one[0]};
    st2_plus  = {1'b0, st1_plus[DIGITS-1:0]}  + {1'b0, bus.residue_plus}
              + {{DIGITS{1'b0}}, bus.cin_two[1]};
    st2_minus = {1'b0, st1_minus[DIGITS-1:0]} + {1'b0, bus.residue_minus}
              + {{DIGITS{1'b0}}, bus.cin_two[0]};
    cout_one_d = {st1_plus[DIGITS], st1_minus[DIGITS]};
    cout_two_d = {st2_plus[DIGITS], st2_minus[DIGITS]};
  end

  assign bus.sum_plus  = st2_plus[DIGITS-1:0];
  assign bus.sum_minus = st2_minus[DIGITS-1:0];
  assign bus.cout_one  = cout_one_d;
  assign bus.cout_two  = cout_two_d;

  sd_carry_reg u_cin_one (
    .clk  (clk),
    .rst  (rst),
    .en_i (bus.carry_en),
    .d_i  (cout_one_d),
    .q_o  (bus.cin_one)
  );

  sd_carry_reg u_cin_two (
    .clk  (clk),
    .rst  (rst),
    .en_i (bus.carry_en),
    .d_i  (cout_two_d),
    .q_o  (bus.cin_two)
  );

  // M function: R = value(v_top) - 8*P spans -23..23, so 6 signed bits suffice
  logic signed [5:0] m_r;
  logic        [5:0] m_mag;
  logic              m_sat;
  logic        [2:0] m_w;

  always_comb begin
    m_r   = 6'(sd_value(bus.v_top_plus, bus.v_top_minus)
               - 8 * (int'(bus.p[1]) - int'(bus.p[0])));
    m_mag = m_r[5] ? 6'(-m_r) : m_r;
    m_sat = (m_mag > 6'd7);
    m_w   = m_sat ? 3'd7 : m_mag[2:0];
  end

  // Magnitude goes on exactly one rail, so the result is always canonical
  assign bus.w_upper_plus  = m_r[5] ? 3'd0 : m_w;
  assign bus.w_upper_minus = m_r[5] ? m_w  : 3'd0;

`ifdef SD_M_OVF_FLAG_EN
  assign m_ovf = m_sat;
`endif

endmodule

// File: tb/tb_sd_adder_m_slice.sv
// tb/tb_sd_adder_m_slice.sv - self-checking bench for sd_adder_m_slice against an arithmetic model
module tb_sd_adder_m_slice;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sd_adder_m_slice_if bus ();
`ifdef SD_M_OVF_FLAG_EN
  logic m_ovf;
`endif

  sd_adder_m_slice dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus)
`ifdef SD_M_OVF_FLAG_EN
    ,
    .m_ovf  (m_ovf)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [1:0] mc1 = 2'b00;
  logic [1:0] mc2 = 2'b00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add_rail(input int xv, input int yv, input int rv, input int c1i, input int c2i,
                          output int sum, output int co1, output int co2);
    int s1;
    int s2;
    s1  = xv + yv + c1i;
    co1 = s1 / 16;
    s2  = (s1 % 16) + rv + c2i;
    co2 = s2 / 16;
    sum = s2 % 16;
  endtask

  task automatic model_add(output logic [3:0] sp, output logic [3:0] sm,
                           output logic [1:0] c1, output logic [1:0] c2);
    int s, a, b;
    add_rail(int'(bus.x_plus), int'(bus.y_plus), int'(bus.residue_plus),
             int'(mc1[1]), int'(mc2[1]), s, a, b);
    sp = 4'(s); c1[1] = a[0]; c2[1] = b[0];
    add_rail(int'(bus.x_minus), int'(bus.y_minus), int'(bus.residue_minus),
             int'(mc1[0]), int'(mc2[0]), s, a, b);
    sm = 4'(s); c1[0] = a[0]; c2[0] = b[0];
  endtask

  task automatic model_m(output logic [2:0] wp, output logic [2:0] wm, output logic ovf);
    int r;
    int mag;
    r   = (int'(bus.v_top_plus) - int'(bus.v_top_minus)) - 8 * (int'(bus.p[1]) - int'(bus.p[0]));
    mag = (r < 0) ? -r : r;
    ovf = (mag > 7);
    if (mag > 7) mag = 7;
    wp = (r >= 0) ? 3'(mag) : 3'd0;
    wm = (r < 0)  ? 3'(mag) : 3'd0;
  endtask

  task automatic check_all(input string tag);
    logic [3:0] sp, sm;
    logic [1:0] c1, c2;
    logic [2:0] wp, wm;
    logic ovf;
    int lhs, rhs;
    model_add(sp, sm, c1, c2);
    model_m(wp, wm, ovf);
    chk({tag, ".sum_plus"},  32'(bus.sum_plus),  32'(sp));
    chk({tag, ".sum_minus"}, 32'(bus.sum_minus), 32'(sm));
    chk({tag, ".cout_one"},  32'(bus.cout_one),  32'(c1));
    chk({tag, ".cout_two"},  32'(bus.cout_two),  32'(c2));
    chk({tag, ".cin_one"},   32'(bus.cin_one),   32'(mc1));
    chk({tag, ".cin_two"},   32'(bus.cin_two),   32'(mc2));
    chk({tag, ".w_plus"},    32'(bus.w_upper_plus),  32'(wp));
    chk({tag, ".w_minus"},   32'(bus.w_upper_minus), 32'(wm));
`ifdef SD_M_OVF_FLAG_EN
    chk({tag, ".m_ovf"},     32'(m_ovf), 32'(ovf));
`endif
    lhs = (int'(bus.sum_plus) - int'(bus.sum_minus))
        + 16 * ((int'(bus.cout_one[1]) - int'(bus.cout_one[0]))
              + (int'(bus.cout_two[1]) - int'(bus.cout_two[0])));
    rhs = (int'(bus.x_plus) - int'(bus.x_minus)) + (int'(bus.y_plus) - int'(bus.y_minus))
        + (int'(bus.residue_plus) - int'(bus.residue_minus))
        + (int'(mc1[1]) - int'(mc1[0])) + (int'(mc2[1]) - int'(mc2[0]));
    chk({tag, ".invariant"}, 32'(lhs), 32'(rhs));
  endtask

  task automatic tick(input logic en);
    logic [3:0] sp, sm;
    logic [1:0] c1, c2;
    bus.carry_en = en;
    model_add(sp, sm, c1, c2);
    @(posedge clk);
    if (en) begin
      mc1 = c1;
      mc2 = c2;
    end
    #1;
    bus.carry_en = 1'b0;
  endtask

  task automatic set_add(input logic [3:0] xp, input logic [3:0] xm, input logic [3:0] yp,
                         input logic [3:0] ym, input logic [3:0] rp, input logic [3:0] rm);
    bus.x_plus = xp; bus.x_minus = xm;
    bus.y_plus = yp; bus.y_minus = ym;
    bus.residue_plus = rp; bus.residue_minus = rm;
  endtask

  initial begin
    rst = 1'b1;
    bus.carry_en = 1'b0;
    set_add(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    bus.v_top_plus = 4'd0; bus.v_top_minus = 4'd0; bus.p = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset.cin_one", 32'(bus.cin_one), 32'd0);
    chk("reset.cin_two", 32'(bus.cin_two), 32'd0);

    // Plain add 3 + 5 + 1
    set_add(4'b0011, 4'd0, 4'b0101, 4'd0, 4'b0001, 4'd0);
    #1;
    chk("plain.sum_plus", 32'(bus.sum_plus), 32'b1001);
    chk("plain.sum_minus", 32'(bus.sum_minus), 32'd0);
    chk("plain.couts", 32'({bus.cout_one, bus.cout_two}), 32'd0);
    check_all("plain");

    // Stage-1 plus carry, then applied next cycle
    set_add(4'b1111, 4'd0, 4'b0001, 4'd0, 4'd0, 4'd0);
    #1;
    chk("s1.cout_one", 32'(bus.cout_one), 32'b10);
    chk("s1.sum", 32'({bus.sum_plus, bus.sum_minus}), 32'd0);
    tick(1'b1);
    chk("s1.cin_one", 32'(bus.cin_one), 32'b10);
    set_add(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    #1;
    chk("s1.applied_sum", 32'(bus.sum_plus), 32'b0001);
    check_all("s1");

    // Hold with carry_en low, then async reset between edges
    tick(1'b0);
    chk("hold.cin_one", 32'(bus.cin_one), 32'b10);
    #1 rst = 1'b1;
    #1;
    mc1 = 2'b00; mc2 = 2'b00;
    chk("arst.cin_one", 32'(bus.cin_one), 32'd0);
    chk("arst.cin_two", 32'(bus.cin_two), 32'd0);
    chk("arst.sum_plus", 32'(bus.sum_plus), 32'd0);
    #1 rst = 1'b0;

    // Stage-2 minus carry
    set_add(4'd0, 4'b1000, 4'd0, 4'd0, 4'd0, 4'b1000);
    #1;
    chk("s2.cout_two", 32'(bus.cout_two), 32'b01);
    chk("s2.sum_minus", 32'(bus.sum_minus), 32'd0);
    chk("s2.cout_one", 32'(bus.cout_one), 32'd0);
    check_all("s2");

    // M normal and saturating cases
    bus.v_top_plus = 4'b1011; bus.v_top_minus = 4'd0; bus.p = 2'b10; #1;
    chk("m1.w", 32'({bus.w_upper_plus, bus.w_upper_minus}), 32'({3'b011, 3'b000}));
    bus.v_top_plus = 4'd0; bus.v_top_minus = 4'b0110; bus.p = 2'b00; #1;
    chk("m2.w", 32'({bus.w_upper_plus, bus.w_upper_minus}), 32'({3'b000, 3'b110}));
    bus.v_top_plus = 4'b0110; bus.v_top_minus = 4'd0; bus.p = 2'b10; #1;
    chk("m3.w", 32'({bus.w_upper_plus, bus.w_upper_minus}), 32'({3'b000, 3'b010}));
    bus.v_top_plus = 4'b1011; bus.v_top_minus = 4'd0; bus.p = 2'b01; #1;
    chk("msat19.w", 32'({bus.w_upper_plus, bus.w_upper_minus}), 32'({3'b111, 3'b000}));
`ifdef SD_M_OVF_FLAG_EN
    chk("msat19.ovf", 32'(m_ovf), 32'd1);
`endif
    bus.p = 2'b11; #1;
    chk("msat11.w", 32'({bus.w_upper_plus, bus.w_upper_minus}), 32'({3'b111, 3'b000}));
`ifdef SD_M_OVF_FLAG_EN
    chk("msat11.ovf", 32'(m_ovf), 32'd1);
`endif
    bus.v_top_plus = 4'd0; bus.v_top_minus = 4'b1111; bus.p = 2'b10; #1;
    check_all("msat_neg");

    // Randomized operands, carry chaining and occasional mid-cycle reset
    for (int i = 0; i < 300; i++) begin
      set_add(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      bus.v_top_plus = 4'($urandom); bus.v_top_minus = 4'($urandom); bus.p = 2'($urandom);
      #1;
      check_all("rand");
      tick(1'($urandom));
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        #1;
        mc1 = 2'b00; mc2 = 2'b00;
        check_all("rand_rst");
        rst = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
